// File: rtl/bt656_rx_axis.sv
// BT.656 receiver: decodes EAV/SAV-framed CbYCrY samples and packs YCbCr pixels into AXI-Stream words.
// Optional macro BT656_XY_PROTECT_EN enables XY protection-bit checking with an xy_err pulse.
module bt656_rx_axis #(
    parameter int DATA_W            = 10,
    parameter int AXIS_DWIDTH       = 128,
    parameter int PIXELS_PER_SYMBOL = 4,
    parameter int LINES_CNT_W       = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      vid_data,
    input  logic                   vid_ce,
    input  logic                   enable,
    output logic [AXIS_DWIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic                   field_o,
    output logic [LINES_CNT_W-1:0] line_cnt,
    output logic [15:0]            pix_per_line,
    output logic                   overflow,
    output logic                   xy_err
);
    localparam int SLOT_W = (PIXELS_PER_SYMBOL > 1) ? $clog2(PIXELS_PER_SYMBOL) : 1;

    typedef enum logic [2:0] {BLANK, TRS1, TRS2, TRS3, ACTIVE} state_t;
    state_t state_q, state_d;

    logic [7:0]             s;
    logic                   f_b, v_b, h_b, xy_ok;
    logic [1:0]             phase_q, phase_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [15:0]            pix_cnt_q, pix_cnt_d;
    logic [7:0]             chroma_q, chroma_d;
    logic [AXIS_DWIDTH-1:0] acc_q, acc_d, acc_new, pend_q, pend_d;
    logic                   pend_vld_q, pend_vld_d, line_open_q, line_open_d;
    logic                   v_q, v_d, field_q, field_d, xy_err_q, xy_err_d;
    logic [LINES_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [15:0]            ppl_q, ppl_d;
    logic                   ovf_q, tuser_pend_q, tuser_set;
    logic                   push, push_last, accept, pop;
    logic [AXIS_DWIDTH-1:0] push_data;
    logic [AXIS_DWIDTH-1:0] mem_q [2];
    logic [1:0]             last_q, user_q, cnt_q;
    logic                   wr_ptr_q, rd_ptr_q;
    logic                   vid_unused;

    assign s   = vid_data[DATA_W-1 -: 8];
    assign f_b = s[6];
    assign v_b = s[5];
    assign h_b = s[4];
    assign vid_unused = ^{vid_data[DATA_W-9:0], s[7]};

`ifdef BT656_XY_PROTECT_EN
    assign xy_ok = s[7] && (s[3] == (v_b ^ h_b)) && (s[2] == (f_b ^ h_b)) &&
                   (s[1] == (f_b ^ v_b)) && (s[0] == (f_b ^ v_b ^ h_b));
`else
    assign xy_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        slot_d      = slot_q;
        pix_cnt_d   = pix_cnt_q;
        chroma_d    = chroma_q;
        acc_d       = acc_q;
        acc_new     = acc_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        line_open_d = line_open_q;
        v_d         = v_q;
        field_d     = field_q;
        line_cnt_d  = line_cnt_q;
        ppl_d       = ppl_q;
        xy_err_d    = 1'b0;
        tuser_set   = 1'b0;
        push        = 1'b0;
        push_last   = 1'b0;
        push_data   = pend_q;
        if (vid_ce) begin
            case (state_q)
                BLANK:  if (s == 8'hFF) state_d = TRS1;
                TRS1:   state_d = (s == 8'h00) ? TRS2 : BLANK;
                TRS2:   state_d = (s == 8'h00) ? TRS3 : BLANK;
                TRS3: begin
                    state_d = BLANK;
                    // Any XY, even a rejected one, closes a line still open
                    if (line_open_q) begin
                        line_open_d = 1'b0;
                        pend_vld_d  = 1'b0;
                        ppl_d       = pix_cnt_q;
                        if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 1'b1;
                        if (pend_vld_q) begin
                            push      = 1'b1;
                            push_last = 1'b1;
                        end else if (slot_q != '0) begin
                            push      = 1'b1;
                            push_last = 1'b1;
                            push_data = acc_q;
                        end
                    end
                    if (!xy_ok) begin
                        xy_err_d = 1'b1;
                    end else begin
                        field_d = f_b;
                        v_d     = v_b;
                        if (v_q && !v_b) begin
                            line_cnt_d = '0;
                            tuser_set  = !f_b;
                        end
                        if (!h_b && !v_b && enable) begin
                            state_d     = ACTIVE;
                            phase_d     = 2'd0;
                            slot_d      = '0;
                            pix_cnt_d   = '0;
                            acc_d       = '0;
                            line_open_d = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (s == 8'hFF) begin
                        state_d = TRS1;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        case (phase_q)
                            2'd0: begin
                                chroma_d = s;
                                if (pend_vld_q) begin
                                    push       = 1'b1;
                                    pend_vld_d = 1'b0;
                                end
                            end
                            2'd2: chroma_d = s;
                            default: begin
                                acc_new[slot_q*32 +: 32] = {s, chroma_q, 16'h0000};
                                pix_cnt_d = pix_cnt_q + 16'd1;
                                if (slot_q == SLOT_W'(PIXELS_PER_SYMBOL-1)) begin
                                    pend_d     = acc_new;
                                    pend_vld_d = 1'b1;
                                    acc_d      = '0;
                                    slot_d     = '0;
                                end else begin
                                    acc_d  = acc_new;
                                    slot_d = slot_q + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: state_d = BLANK;
            endcase
        end
    end

    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign accept        = push && ((cnt_q != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BLANK;
            phase_q      <= '0;
            slot_q       <= '0;
            pix_cnt_q    <= '0;
            chroma_q     <= '0;
            acc_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            line_open_q  <= 1'b0;
            v_q          <= 1'b0;
            field_q      <= 1'b0;
            line_cnt_q   <= '0;
            ppl_q        <= '0;
            xy_err_q     <= 1'b0;
            ovf_q        <= 1'b0;
            tuser_pend_q <= 1'b0;
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            last_q       <= '0;
            user_q       <= '0;
            cnt_q        <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            slot_q      <= slot_d;
            pix_cnt_q   <= pix_cnt_d;
            chroma_q    <= chroma_d;
            acc_q       <= acc_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            line_open_q <= line_open_d;
            v_q         <= v_d;
            field_q     <= field_d;
            line_cnt_q  <= line_cnt_d;
            ppl_q       <= ppl_d;
            xy_err_q    <= xy_err_d;
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            if (accept) begin
                mem_q[wr_ptr_q]  <= push_data;
                last_q[wr_ptr_q] <= push_last;
                user_q[wr_ptr_q] <= tuser_pend_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, accept} - {1'b0, pop};
            if (push && !accept) ovf_q <= 1'b1;
            // A dropped word leaves tuser pending for the next surviving one
            if (tuser_set)   tuser_pend_q <= 1'b1;
            else if (accept) tuser_pend_q <= 1'b0;
        end
    end

    assign m_axis_tdata = mem_q[rd_ptr_q];
    assign m_axis_tlast = m_axis_tvalid && last_q[rd_ptr_q];
    assign m_axis_tuser = m_axis_tvalid && user_q[rd_ptr_q];
    assign field_o      = field_q;
    assign line_cnt     = line_cnt_q;
    assign pix_per_line = ppl_q;
    assign overflow     = ovf_q;
    assign xy_err       = xy_err_q;
endmodule
